vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameters SHALL be one per line:
- H_ACTIVE, 640, active pixels per line
- H_SYNC, 96, hsync width in pixels
- H_BP, 48, horizontal back porch in pixels
- H_TOTAL, 800, pixels per line
- V_ACTIVE, 480, active lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- V_TOTAL, 525, lines per frame
REQ-002 Ports SHALL be one per line:
- i_clk, in, 1, system clock
- i_rst, in, 1, asynchronous active-high reset
- i_pix_stb, in, 1, one-clk pixel strobe
- i_hs, in, 1, hsync, active low
- i_vs, in, 1, vsync, active low
- i_rgb, in, 12, pixel {R,G,B} 4:4:4
- o_x, out, 10, active pixel column
- o_y, out, 9, active line
- o_de, out, 1, active pixel valid
- o_rgb, out, 12, registered pixel
- o_sof, out, 1, first active pixel of frame
- o_locked, out, 1, timing locked
- o_err, out, 1, timing error pulse
- o_csum, out, 16, frame checksum
- o_csum_vld, out, 1, checksum valid pulse
REQ-003 Clock and reset SHALL be one clock i_clk with asynchronous active-high reset i_rst; all state SHALL be in the i_clk domain.

Function
REQ-004 i_hs, i_vs and i_rgb SHALL be sampled only in cycles where i_pix_stb=1; each such cycle is called a strobe.
REQ-005 The hs falling edge SHALL be detected as current hs=0 with previous hs=1; at that strobe hcnt SHALL be 0, otherwise hcnt SHALL increment and saturate at 2047 (11 bits).
REQ-006 A vs falling edge SHALL set a pending flag. At the next hs falling edge, or the same strobe if both fall together, vcnt SHALL load 0 and the flag SHALL clear. Other hs falling edges SHALL increment vcnt, saturating at 1023.
REQ-007 The pixel SHALL be active when hcnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] = [144,783] and vcnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1] = [35,514].
REQ-008 For an active pixel, x SHALL be hcnt-144 and y SHALL be vcnt-35.
REQ-009 The lock FSM SHALL have the states SEARCH, CHECK and LOCKED.
- SEARCH -> CHECK on a vcnt reload.
- CHECK -> LOCKED at the next vcnt reload if every line was H_TOTAL long and the frame was V_TOTAL lines; otherwise CHECK -> SEARCH.
REQ-010 A line is good when hcnt==H_TOTAL-1 at the hs falling edge. A frame is good when vcnt==V_TOTAL-1 at the reload.
REQ-011 In LOCKED, any bad line, bad frame, or hcnt reaching H_TOTAL without an hs edge SHALL pulse o_err for one clk and move the FSM to SEARCH.
REQ-012 o_locked SHALL be 1 only in LOCKED, and o_de SHALL be (active AND LOCKED).
REQ-013 Latency: a pixel sampled at strobe k SHALL drive o_x, o_y, o_de and o_rgb from the clock edge of strobe k+1, held until the next strobe.
REQ-014 o_sof SHALL be 1 for one clk, coincident with the first o_de update, where x=0, y=0 and LOCKED.
REQ-015 When o_de=0, o_x, o_y and o_rgb SHALL hold their last values.

Reset
REQ-016 While i_rst=1, the FSM SHALL be SEARCH; hcnt, vcnt and the pending flag SHALL be 0; the sampled hs and vs history SHALL be 1; and every output SHALL be 0.
REQ-017 Reset asserted mid-frame SHALL discard lock and any partial checksum; reacquisition SHALL require a full CHECK frame.

Configuration
REQ-018 Macro VGA_RX_CHECKSUM_EN, when defined, SHALL enable the frame checksum:
- o_csum SHALL be the mod-2^16 sum of zero-extended i_rgb over all o_de pixels of a frame.
- o_csum SHALL latch at the vcnt reload ending a LOCKED frame, with o_csum_vld pulsed for one clk.
- The accumulator SHALL clear at that reload.
REQ-019 When VGA_RX_CHECKSUM_EN is not defined, o_csum and o_csum_vld SHALL be tied to 0 and no accumulator logic SHALL exist.

Verification
REQ-020 The bench SHALL cover these scenarios, with a 25 MHz strobe (1 of 4 clks) and nominal 640x480 timing:
- Reset, then frames from a 640x480 generator -> o_locked=1 after the second vs edge; first o_sof with x=0,y=0; 307200 o_de pulses per frame.
- One line shortened to 799 pixels while LOCKED -> o_err one-clk pulse, o_locked=0, o_locked=1 again two frames later.
- hs held high for 900 strobes while LOCKED -> o_err at hcnt=800, no o_de during the stall.
- Constant i_rgb=12'h001 with checksum enabled -> o_csum=16'hB000 (307200 mod 65536) with o_csum_vld once per frame; with the macro undefined -> o_csum=0.
- i_rst pulsed at line 200 -> all outputs 0 immediately, re-lock after two full frames.
- vs and hs falling on the same strobe -> vcnt=0 on that strobe; the frame is counted as 525 lines and lock is held.

Source files
------------

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel coordinates and a lock indication from a
// strobed VGA stream (active-low hsync/vsync, 12-bit RGB). Counters run on
// pixel strobes; pixel outputs lag the sampled pixel by one strobe.
// Optional frame checksum: define VGA_RX_CHECKSUM_EN to enable o_csum/o_csum_vld.
module vga_sync_rx #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_TOTAL  = 525
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [11:0] i_rgb,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_de,
    output logic [11:0] o_rgb,
    output logic        o_sof,
    output logic        o_locked,
    output logic        o_err,
    output logic [15:0] o_csum,
    output logic        o_csum_vld
);
    localparam logic [10:0] H_START  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_LAST   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [10:0] H_END    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_START  = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_LAST   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0]  V_END    = 10'(V_TOTAL - 1);
    localparam logic [10:0] HCNT_MAX = 11'h7FF;
    localparam logic [9:0]  VCNT_MAX = 10'h3FF;

    typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        hs_q, hs_d, vs_q, vs_d, pend_q, pend_d, bad_q, bad_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [11:0] pix_q, pix_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        de_q, de_d, sof_q, sof_d, err_q, err_d;
    logic [11:0] rgb_q, rgb_d;

    logic hs_fall, vs_fall, reload, line_good, frame_good, overrun, active;

    // A reload is the hs edge that starts a new frame (vs edge pending or coincident).
    assign hs_fall    = i_pix_stb & hs_q & ~i_hs;
    assign vs_fall    = i_pix_stb & vs_q & ~i_vs;
    assign reload     = hs_fall & (pend_q | vs_fall);
    assign line_good  = (hcnt_q == H_END);
    assign frame_good = (vcnt_q == V_END);
    assign overrun    = i_pix_stb & ~hs_fall & (hcnt_q == H_END);
    // Activity of the pixel sampled at the previous strobe (held in pix_q).
    assign active     = (hcnt_q >= H_START) && (hcnt_q <= H_LAST) &&
                        (vcnt_q >= V_START) && (vcnt_q <= V_LAST);

    // Lock FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= SEARCH;
        else       state_q <= state_d;
    end

    // Lock FSM next state; a CHECK frame must be clean end to end before LOCKED.
    always_comb begin
        state_d = state_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        case (state_q)
            SEARCH: begin
                if (reload) begin
                    state_d = CHECK;
                    bad_d   = 1'b0;
                end
            end
            CHECK: begin
                if (reload) begin
                    state_d = (!bad_q && line_good && frame_good) ? LOCKED : SEARCH;
                end else if ((hs_fall && !line_good) || overrun) begin
                    bad_d = 1'b1;
                end
            end
            LOCKED: begin
                if ((hs_fall && !line_good) || (reload && !frame_good) || overrun) begin
                    err_d   = 1'b1;
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Sync history, saturating counters and the pending-vsync flag.
    always_comb begin
        hs_d   = hs_q;
        vs_d   = vs_q;
        pix_d  = pix_q;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        pend_d = pend_q;
        if (i_pix_stb) begin
            hs_d  = i_hs;
            vs_d  = i_vs;
            pix_d = i_rgb;
            if (hs_fall)                hcnt_d = '0;
            else if (hcnt_q != HCNT_MAX) hcnt_d = hcnt_q + 11'd1;
        end
        if (reload) begin
            vcnt_d = '0;
            pend_d = 1'b0;
        end else begin
            if (hs_fall && vcnt_q != VCNT_MAX) vcnt_d = vcnt_q + 10'd1;
            if (vs_fall)                       pend_d = 1'b1;
        end
    end

    // Pixel outputs update once per strobe; x/y/rgb hold while not displaying.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        rgb_d = rgb_q;
        de_d  = de_q;
        sof_d = 1'b0;
        if (i_pix_stb) begin
            de_d = active && (state_q == LOCKED);
            if (de_d) begin
                x_d   = 10'(hcnt_q - H_START);
                y_d   = 9'(vcnt_q - V_START);
                rgb_d = pix_q;
                sof_d = (hcnt_q == H_START) && (vcnt_q == V_START);
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            pend_q <= 1'b0;
            bad_q  <= 1'b0;
            hcnt_q <= '0;
            vcnt_q <= '0;
            pix_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            rgb_q  <= '0;
            de_q   <= 1'b0;
            sof_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            pend_q <= pend_d;
            bad_q  <= bad_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            pix_q  <= pix_d;
            x_q    <= x_d;
            y_q    <= y_d;
            rgb_q  <= rgb_d;
            de_q   <= de_d;
            sof_q  <= sof_d;
            err_q  <= err_d;
        end
    end

    assign o_x      = x_q;
    assign o_y      = y_q;
    assign o_rgb    = rgb_q;
    assign o_de     = de_q;
    assign o_sof    = sof_q;
    assign o_err    = err_q;
    assign o_locked = (state_q == LOCKED);

`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] acc_q, acc_d, csum_q, csum_d;
    logic        csum_vld_q, csum_vld_d;

    // Sum displayed pixels; publish only for a frame that stayed LOCKED to its end.
    always_comb begin
        acc_d      = acc_q;
        csum_d     = csum_q;
        csum_vld_d = 1'b0;
        if (reload) begin
            acc_d = '0;
            if (state_q == LOCKED && state_d == LOCKED) begin
                csum_d     = acc_q;
                csum_vld_d = 1'b1;
            end
        end else if (de_d && i_pix_stb) begin
            acc_d = acc_q + 16'(pix_q);
        end
    end

    // Checksum registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q      <= '0;
            csum_q     <= '0;
            csum_vld_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            csum_q     <= csum_d;
            csum_vld_q <= csum_vld_d;
        end
    end

    assign o_csum     = csum_q;
    assign o_csum_vld = csum_vld_q;
`else
    assign o_csum     = '0;
    assign o_csum_vld = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx on a scaled-down raster (16x10 total,
// 8x4 active) so that many frames fit in a short run. The generator pushes
// expected display pixels and checksums; a negedge monitor pops and compares.
module tb_vga_sync_rx;
    localparam int HA = 8, HS = 2, HB = 2, HT = 16;
    localparam int VA = 4, VS = 1, VB = 2, VT = 10;
    localparam int HST = HS + HB, VST = VS + VB;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1, i_pix_stb = 1'b0, i_hs = 1'b1, i_vs = 1'b1;
    logic [11:0] i_rgb = 12'h0;
    logic [9:0]  o_x;
    logic [8:0]  o_y;
    logic        o_de, o_sof, o_locked, o_err, o_csum_vld;
    logic [11:0] o_rgb;
    logic [15:0] o_csum;

    always #5 clk = ~clk;

    vga_sync_rx #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_hs(i_hs),
        .i_vs(i_vs), .i_rgb(i_rgb), .o_x(o_x), .o_y(o_y), .o_de(o_de),
        .o_rgb(o_rgb), .o_sof(o_sof), .o_locked(o_locked), .o_err(o_err),
        .o_csum(o_csum), .o_csum_vld(o_csum_vld)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [11:0] rgb;
        logic        sof;
    } pix_t;

    pix_t        sbq[$];
    logic [15:0] csq[$];
    pix_t        mon_e;
    logic [15:0] mon_c;
    int n_cmp = 0, n_fail = 0, err_cycles = 0, exp_err = 0, de_frame = 0;
    logic stb_seen = 1'b0, err_at_stb = 1'b0;

    always @(posedge clk) stb_seen <= i_pix_stb;

    // Monitor: compares every display update and checksum pulse against the queues.
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_err) err_cycles++;
            if (stb_seen && o_de) begin
                de_frame++;
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_de: got x=%0d y=%0d, required no display", o_x, o_y);
                end else begin
                    mon_e = sbq.pop_front();
                    if (o_x !== mon_e.x || o_y !== mon_e.y || o_rgb !== mon_e.rgb || o_sof !== mon_e.sof) begin
                        n_fail++;
                        $display("FAIL pixel: got x=%0d y=%0d rgb=%h sof=%b, required x=%0d y=%0d rgb=%h sof=%b",
                                 o_x, o_y, o_rgb, o_sof, mon_e.x, mon_e.y, mon_e.rgb, mon_e.sof);
                    end
                end
            end else if (o_sof) begin
                n_fail++;
                $display("FAIL sof_without_update: got sof=1, required 0");
            end
            if (o_csum_vld) begin
                n_cmp++;
`ifdef VGA_RX_CHECKSUM_EN
                if (csq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_csum: got csum=%h, required no pulse", o_csum);
                end else begin
                    mon_c = csq.pop_front();
                    if (o_csum !== mon_c) begin
                        n_fail++;
                        $display("FAIL csum: got %h, required %h", o_csum, mon_c);
                    end
                end
`else
                n_fail++;
                $display("FAIL csum_vld: got 1, required 0 with checksum disabled");
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_pix"}, 64'({o_x, o_y, o_de, o_rgb, o_sof}), 64'd0);
        chk({name, "_ctl"}, 64'({o_locked, o_err, o_csum, o_csum_vld}), 64'd0);
    endtask

    // One strobe cycle followed by three idle clocks (25 MHz on a 100 MHz clock).
    task automatic strobe(input logic h, input logic v, input logic [11:0] c);
        i_pix_stb = 1'b1;
        i_hs = h;
        i_vs = v;
        i_rgb = c;
        @(posedge clk); #1;
        err_at_stb = o_err;
        i_pix_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        #1;
        check_zero("rst_mid_frame");
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic run_frame(input bit ex, input int short_l, input int stall_l,
                             input int rst_l, input bit vs_early, input logic [11:0] crgb);
        bit          on;
        logic [15:0] fsum;
        int          len;
        logic        h, v;
        logic [11:0] c;
        pix_t        e;
        on = ex;
        fsum = 16'h0;
        de_frame = 0;
        for (int l = 0; l < VT; l++) begin
            if (l == rst_l) begin
                pulse_reset();
                on = 1'b0;
            end
            if (l == stall_l) begin
                on = 1'b0;
                for (int s = 0; s < 40; s++) begin
                    strobe(1'b1, 1'b1, 12'h5A5);
                    if (s == 0) begin
                        chk("stall_err_pulse", 64'(err_at_stb), 64'(ex));
                        chk("stall_unlock", 64'(o_locked), 64'd0);
                    end
                end
            end
            len = (l == short_l) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                h = (p < HS) ? 1'b0 : 1'b1;
                v = (l < VS) ? 1'b0 : 1'b1;
                if (vs_early && l == VT - 1 && p >= HT - 4) v = 1'b0;
                c = (crgb != 12'h0) ? crgb : {4'(l), 8'(p * 5)};
                if (on && p >= HST && p < HST + HA && l >= VST && l < VST + VA) begin
                    e.x = 10'(p - HST);
                    e.y = 9'(l - VST);
                    e.rgb = c;
                    e.sof = (p == HST && l == VST);
                    sbq.push_back(e);
                    fsum += 16'(c);
                end
                strobe(h, v, c);
                if (short_l >= 0 && l == short_l + 1 && p == 0) begin
                    chk("short_line_err_pulse", 64'(err_at_stb), 64'(ex));
                    chk("short_line_unlock", 64'(o_locked), 64'd0);
                end
            end
            if (l == short_l) on = 1'b0;
        end
        if (ex && (short_l >= 0 || stall_l >= 0)) exp_err++;
        chk("frame_end_locked", 64'(o_locked), 64'(on));
        chk("err_pulse_count", 64'(err_cycles), 64'(exp_err));
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        if (on) begin
            chk("de_per_frame", 64'(de_frame), 64'(HA * VA));
`ifdef VGA_RX_CHECKSUM_EN
            csq.push_back(fsum);
`endif
        end
`ifndef VGA_RX_CHECKSUM_EN
        chk("csum_tied_zero", 64'(o_csum), 64'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        i_rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        run_frame(1'b0, -1, -1, -1, 1'b0, 12'h000); // f0: CHECK frame, no display
        run_frame(1'b1, -1, -1, -1, 1'b0, 12'h000); // f1: first locked frame, sof at 0,0
        run_frame(1'b1, -1, -1, -1, 1'b1, 12'h000); // f2: vs falls early, reload via pending
        run_frame(1'b1,  4, -1, -1, 1'b0, 12'h000); // f3: line 4 one pixel short
        run_frame(1'b0, -1, -1, -1, 1'b0, 12'h000); // f4: CHECK
        run_frame(1'b1, -1, -1, -1, 1'b0, 12'hFFF); // f5: relocked, checksum 0xFFE0
        run_frame(1'b1, -1,  5, -1, 1'b0, 12'h000); // f6: hs stall 40 strobes
        run_frame(1'b0, -1, -1, -1, 1'b0, 12'h000); // f7: CHECK
        run_frame(1'b1, -1, -1, -1, 1'b0, 12'h000); // f8: relocked
        run_frame(1'b1, -1, -1,  5, 1'b0, 12'h000); // f9: reset at line 5
        run_frame(1'b0, -1, -1, -1, 1'b0, 12'h000); // f10: CHECK
        run_frame(1'b1, -1, -1, -1, 1'b0, 12'h001); // f11: relocked, checksum 0x0020
        strobe(1'b0, 1'b0, 12'h000);                // vs+hs together close f11
        chk("coincident_reload_lock_held", 64'(o_locked), 64'd1);
        strobe(1'b0, 1'b0, 12'h000);
        repeat (4) strobe(1'b1, 1'b0, 12'h000);
        chk("final_err_count", 64'(err_cycles), 64'(exp_err));
        chk("final_scoreboard_empty", 64'(sbq.size()), 64'd0);
        chk("final_csum_queue_empty", 64'(csq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
